// File: rtl/bfu_pkg.sv
// Shared definitions for the butterfly pipeline: mode encoding and default Dilithium constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bfu_pkg;

  // Operation carried with every beat
  typedef enum logic [1:0] {
    MODE_NTT  = 2'd0,
    MODE_INTT = 2'd1,
    MODE_SKIP = 2'd2,
    MODE_MUL  = 2'd3
  } bfu_mode_e;

  // Default modulus, Q^-1 mod 2^32, and 2^32 mod Q (the Montgomery form of 1)
  localparam int Q_DEF    = 8380417;
  localparam int QINV_DEF = 58728449;
  localparam int MONT     = 4193792;

endpackage

// File: rtl/bfu_lane.sv
// One butterfly lane: stage0 capture, mul, QINV mul, Montgomery reduce, add/sub (+ optional fold).
// Latency: 5 advance cycles, 6 with BFU_PIPE_FREEZE_EN (output mapped into [0, Q)).
// Backpressure: every register loads only on i_adv; valid tracking lives in the parent.
module bfu_lane
  import bfu_pkg::*;
#(
  parameter int DW   = 32,
  parameter int Q    = Q_DEF,
  parameter int QINV = QINV_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_adv,
  input  logic [1:0]    i_mode_s0,
  input  logic [1:0]    i_mode_s3,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [DW-1:0] i_tw,
  output logic [DW-1:0] o_a,
  output logic [DW-1:0] o_b
);

  localparam int W2 = 2 * DW;
  localparam logic signed [DW-1:0] Q_D    = DW'(Q);
  localparam logic signed [W2-1:0] Q_W    = W2'(Q);
  localparam logic        [DW-1:0] QINV_D = DW'(QINV);

  logic signed [DW-1:0] a0, b0, tw0;
  logic signed [DW-1:0] a_sel, b_sel;
  logic signed [W2-1:0] xa1, xb1;
  logic signed [DW-1:0] a1, b1;
  logic signed [DW-1:0] ta2, tb2;
  logic signed [W2-1:0] xa2, xb2;
  logic signed [DW-1:0] a2, b2;
  logic signed [W2-1:0] da, db;
  logic signed [DW-1:0] ma3, mb3, a3, b3;
  logic signed [DW-1:0] res_a, res_b;

  // Stage 0: capture the lane operands
  always_ff @(posedge i_clk) begin
    if (i_adv) begin
      a0  <= i_a;
      b0  <= i_b;
      tw0 <= i_tw;
    end
  end

  // INTT does its add/sub before the multiply (GS); other modes feed a and b straight through
  always_comb begin
    a_sel = a0;
    b_sel = b0;
    if (i_mode_s0 == MODE_INTT) begin
      a_sel = a0 + b0;
      b_sel = a0 - b0;
    end
  end

  // Stage 1: full-width twiddle products; xa only matters for MUL
  always_ff @(posedge i_clk) begin
    if (i_adv) begin
      xa1 <= W2'(a0) * W2'(tw0);
      xb1 <= W2'(b_sel) * W2'(tw0);
      a1  <= a_sel;
      b1  <= b0;
    end
  end

  // Stage 2: t = low half of x*QINV (only the low DW bits of x contribute)
  always_ff @(posedge i_clk) begin
    if (i_adv) begin
      ta2 <= xa1[DW-1:0] * QINV_D;
      tb2 <= xb1[DW-1:0] * QINV_D;
      xa2 <= xa1;
      xb2 <= xb1;
      a2  <= a1;
      b2  <= b1;
    end
  end

  // x - t*Q has an all-zero low half, so the upper half is the reduced value
  always_comb begin
    da = xa2 - W2'(ta2) * Q_W;
    db = xb2 - W2'(tb2) * Q_W;
  end

  // Stage 3: keep the reduced products
  always_ff @(posedge i_clk) begin
    if (i_adv) begin
      ma3 <= da[W2-1:DW];
      mb3 <= db[W2-1:DW];
      a3  <= a2;
      b3  <= b2;
    end
  end

  // Final combine selected by the beat's own mode
  always_comb begin
    res_a = a3;
    res_b = b3;
    case (i_mode_s3)
      MODE_NTT: begin
        res_a = a3 + mb3;
        res_b = a3 - mb3;
      end
      MODE_INTT: begin
        res_a = a3;
        res_b = mb3;
      end
      MODE_MUL: begin
        res_a = ma3;
        res_b = mb3;
      end
      default: begin
        res_a = a3;
        res_b = b3;
      end
    endcase
  end

`ifdef BFU_PIPE_FREEZE_EN
  logic signed [DW-1:0] a4, b4;

  // One conditional correction by Q; two passes bring any value within 2Q of range into [0, Q)
  function automatic logic signed [DW-1:0] fold(input logic signed [DW-1:0] x);
    logic signed [DW-1:0] y;
    y = x;
    if (x[DW-1]) y = x + Q_D;
    else if (x >= Q_D) y = x - Q_D;
    return y;
  endfunction

  // Stage 4: raw butterfly result
  always_ff @(posedge i_clk) begin
    if (i_adv) begin
      a4 <= res_a;
      b4 <= res_b;
    end
  end

  // Stage 5: normalised output register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_a <= '0;
      o_b <= '0;
    end else if (i_adv) begin
      o_a <= fold(fold(a4));
      o_b <= fold(fold(b4));
    end
  end
`else
  // Stage 4: raw butterfly result is the output register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_a <= '0;
      o_b <= '0;
    end else if (i_adv) begin
      o_a <= res_a;
      o_b <= res_b;
    end
  end
`endif

endmodule

// File: rtl/bfu_pipe.sv
// LANES-wide NTT/INTT/SKIP/MUL butterfly with Montgomery reduction; BFU_PIPE_FREEZE_EN adds [0,Q) output fold.
// Latency: 5 accepted-advance cycles (6 with BFU_PIPE_FREEZE_EN); 1 beat/cycle throughput.
// Backpressure: whole pipe stalls while an output beat waits; o_ready = !o_valid | i_ready.
module bfu_pipe
  import bfu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DW    = 32,
  parameter int Q     = Q_DEF,
  parameter int QINV  = QINV_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [1:0]          i_mode,
  input  logic [LANES*DW-1:0] i_a,
  input  logic [LANES*DW-1:0] i_b,
  input  logic [LANES*DW-1:0] i_twiddle,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [LANES*DW-1:0] o_a,
  output logic [LANES*DW-1:0] o_b,
  output logic [1:0]          o_mode
);

`ifdef BFU_PIPE_FREEZE_EN
  localparam int NST = 6;
`else
  localparam int NST = 5;
`endif

  logic             adv;
  logic [NST-1:0]   vld_q;
  logic [1:0]       mode_q [NST-1];

  // The pipe moves only when the output slot is empty or being taken
  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;
  assign o_valid = vld_q[NST-1];

  // Per-stage valid bits and the output mode; cleared by reset so in-flight beats vanish
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= '0;
      o_mode <= 2'd0;
    end else if (adv) begin
      vld_q  <= {vld_q[NST-2:0], i_valid};
      o_mode <= mode_q[NST-2];
    end
  end

  // Mode travels alongside its beat so mode changes never touch beats already in flight
  always_ff @(posedge i_clk) begin
    if (adv) begin
      mode_q[0] <= i_mode;
      for (int k = 1; k < NST - 1; k++) mode_q[k] <= mode_q[k-1];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bfu_lane #(
      .DW   (DW),
      .Q    (Q),
      .QINV (QINV)
    ) u_lane (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_adv     (adv),
      .i_mode_s0 (mode_q[0]),
      .i_mode_s3 (mode_q[3]),
      .i_a       (i_a[l*DW +: DW]),
      .i_b       (i_b[l*DW +: DW]),
      .i_tw      (i_twiddle[l*DW +: DW]),
      .o_a       (o_a[l*DW +: DW]),
      .o_b       (o_b[l*DW +: DW])
    );
  end

endmodule

// File: tb/tb_bfu_pipe.sv
// Bench for bfu_pipe: directed butterflies, throughput, stall, mid-flight reset and random traffic.
// Latency expectation follows BFU_PIPE_FREEZE_EN (6) or default (5).
// Backpressure exercised by holding i_ready low with the pipe full and by random i_ready.
module tb_bfu_pipe;
  import bfu_pkg::*;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int W     = LANES * DW;
  localparam int QM    = Q_DEF;
  localparam int QI    = QINV_DEF;
`ifdef BFU_PIPE_FREEZE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [1:0]   i_mode;
  logic [W-1:0] i_a, i_b, i_twiddle;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_a, o_b;
  logic [1:0]   o_mode;

  always #5 i_clk = ~i_clk;

  bfu_pipe #(.LANES(LANES), .DW(DW), .Q(QM), .QINV(QI)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_mode    (i_mode),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_twiddle (i_twiddle),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_a       (o_a),
    .o_b       (o_b),
    .o_mode    (o_mode)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   mode;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         last_xfer;
  int         cur_a[LANES], cur_b[LANES], cur_tw[LANES];
  logic [1:0] cur_mode;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Montgomery reduction straight from its arithmetic definition
  function automatic int mont(input longint x);
    int     t;
    longint d;
    t = int'(x * longint'(QI));
    d = x - longint'(t) * longint'(QM);
    return int'(d >>> DW);
  endfunction

  function automatic int fold(input int x);
    if (x < 0) return x + QM;
    if (x >= QM) return x - QM;
    return x;
  endfunction

  function automatic int fin(input int x);
`ifdef BFU_PIPE_FREEZE_EN
    return fold(fold(x));
`else
    return x;
`endif
  endfunction

  // Expected result of the beat currently being offered
  task automatic push_model();
    exp_t e;
    int   ra, rb, d;
    for (int l = 0; l < LANES; l++) begin
      case (cur_mode)
        2'd0: begin
          d  = mont(longint'(cur_b[l]) * cur_tw[l]);
          ra = cur_a[l] + d;
          rb = cur_a[l] - d;
        end
        2'd1: begin
          d  = cur_a[l] - cur_b[l];
          ra = cur_a[l] + cur_b[l];
          rb = mont(longint'(d) * cur_tw[l]);
        end
        2'd2: begin
          ra = cur_a[l];
          rb = cur_b[l];
        end
        default: begin
          ra = mont(longint'(cur_a[l]) * cur_tw[l]);
          rb = mont(longint'(cur_b[l]) * cur_tw[l]);
        end
      endcase
      e.a[l*DW +: DW] = fin(ra);
      e.b[l*DW +: DW] = fin(rb);
    end
    e.mode = cur_mode;
    sb.push_back(e);
  endtask

  // One clock: sample both handshakes away from the edge, score, then advance to next negedge
  task automatic tick();
    exp_t e;
    #1;
    last_xfer = 1'b0;
    if (i_valid && o_ready && i_rst_n) push_model();
    if (o_valid && i_ready) begin
      last_xfer = 1'b1;
      chk("expected_beat_present", W'(sb.size() != 0), W'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("o_a", o_a, e.a);
        chk("o_b", o_b, e.b);
        chk("o_mode", W'(o_mode), W'(e.mode));
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drive(input logic [1:0] m, input logic v);
    cur_mode = m;
    i_mode   = m;
    i_valid  = v;
    for (int l = 0; l < LANES; l++) begin
      i_a[l*DW +: DW]       = cur_a[l];
      i_b[l*DW +: DW]       = cur_b[l];
      i_twiddle[l*DW +: DW] = cur_tw[l];
    end
  endtask

  // Mix full-range operands (exercises wrap) with in-range ones
  task automatic rnd_ops();
    for (int l = 0; l < LANES; l++) begin
      if ($urandom_range(0, 1) == 1) begin
        cur_a[l] = int'($urandom());
        cur_b[l] = int'($urandom());
      end else begin
        cur_a[l] = int'($urandom_range(0, 2 * QM - 2)) - QM + 1;
        cur_b[l] = int'($urandom_range(0, 2 * QM - 2)) - QM + 1;
      end
      cur_tw[l] = int'($urandom_range(0, QM - 1));
    end
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 60 && sb.size() != 0; k++) tick();
    chk("drained", W'(sb.size()), W'(0));
  endtask

  // Lone beat into an empty pipe: latency plus lane-0 result
  task automatic single(input string tag, input logic [1:0] m, input int a0, input int b0,
                        input int tw0, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    int n;
    rnd_ops();
    cur_a[0]  = a0;
    cur_b[0]  = b0;
    cur_tw[0] = tw0;
    drive(m, 1'b1);
    i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    n = 1;
    while (!o_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, W'(n), W'(LAT));
    chk({tag, "_lane0_a"}, W'(o_a[DW-1:0]), W'(ea));
    chk({tag, "_lane0_b"}, W'(o_b[DW-1:0]), W'(eb));
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   seen_mode[$];
    logic [W-1:0] ha, hb;
    logic [1:0]   hm;
    int           first, last, nx, stale;

    // Reset state
    i_rst_n = 1'b0;
    i_ready = 1'b1;
    rnd_ops();
    drive(2'd0, 1'b0);
    repeat (3) @(negedge i_clk);
    chk("reset_o_valid", W'(o_valid), W'(0));
    chk("reset_o_a", o_a, W'(0));
    chk("reset_o_b", o_b, W'(0));
    chk("reset_o_mode", W'(o_mode), W'(0));
    i_rst_n = 1'b1;
    #1;
    chk("o_ready_after_reset", W'(o_ready), W'(1));
    @(negedge i_clk);

    // Directed butterflies with the Montgomery form of 1 as twiddle
    single("ntt", 2'd0, 5, 3, MONT, 32'(fin(8)), 32'(fin(2)));
    single("intt", 2'd1, 10, 4, MONT, 32'(fin(14)), 32'(fin(6)));
    single("skip", 2'd2, -7, 123, MONT, 32'(fin(-7)), 32'(fin(123)));
    single("mul", 2'd3, 9, -2, MONT, 32'(fin(9)), 32'(fin(-2)));

    // Mode order NTT, SKIP, INTT back-to-back
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rnd_ops();
      drive((k == 0) ? 2'd0 : (k == 1) ? 2'd2 : 2'd1, 1'b1);
      tick();
    end
    i_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (o_valid) seen_mode.push_back(o_mode);
      tick();
    end
    chk("mode_seq_count", W'(seen_mode.size()), W'(3));
    if (seen_mode.size() == 3) begin
      chk("mode_seq_0", W'(seen_mode[0]), W'(0));
      chk("mode_seq_1", W'(seen_mode[1]), W'(2));
      chk("mode_seq_2", W'(seen_mode[2]), W'(1));
    end
    drain();

    // 20 back-to-back beats -> 20 consecutive results
    first = -1;
    last  = -1;
    nx    = 0;
    for (int k = 0; k < 40; k++) begin
      rnd_ops();
      drive(2'($urandom_range(0, 3)), (k < 20) ? 1'b1 : 1'b0);
      tick();
      if (last_xfer) begin
        if (first < 0) first = k;
        last = k;
        nx++;
      end
    end
    chk("b2b_count", W'(nx), W'(20));
    chk("b2b_span", W'(last - first), W'(19));
    chk("b2b_first_at_latency", W'(first), W'(LAT));
    drain();

    // Full pipe, downstream stalls for 7 cycles
    for (int k = 0; k < 8; k++) begin
      rnd_ops();
      drive(2'($urandom_range(0, 3)), 1'b1);
      tick();
    end
    rnd_ops();
    drive(2'($urandom_range(0, 3)), 1'b1);
    i_ready = 1'b0;
    #1;
    ha = o_a;
    hb = o_b;
    hm = o_mode;
    chk("stall_o_valid_at_start", W'(o_valid), W'(1));
    for (int k = 0; k < 7; k++) begin
      tick();
      #1;
      chk("stall_o_ready", W'(o_ready), W'(0));
      chk("stall_o_valid", W'(o_valid), W'(1));
      chk("stall_o_a", o_a, ha);
      chk("stall_o_b", o_b, hb);
      chk("stall_o_mode", W'(o_mode), W'(hm));
    end
    i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      rnd_ops();
      drive(2'($urandom_range(0, 3)), 1'b1);
    end
    drain();

    // Reset with three beats in flight, the oldest already at the output
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rnd_ops();
      drive(2'($urandom_range(0, 3)), 1'b1);
      tick();
    end
    i_valid = 1'b0;
    for (int k = 0; k < LAT - 3; k++) tick();
    chk("pre_reset_o_valid", W'(o_valid), W'(1));
    i_rst_n = 1'b0;
    #1;
    chk("reset_now_o_valid", W'(o_valid), W'(0));
    chk("reset_now_o_a", o_a, W'(0));
    chk("reset_now_o_mode", W'(o_mode), W'(0));
    sb.delete();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    #1;
    chk("o_ready_after_midreset", W'(o_ready), W'(1));
    @(negedge i_clk);
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      if (o_valid) stale++;
      tick();
    end
    chk("no_stale_beats", W'(stale), W'(0));

    // Random traffic with random backpressure and mode mix
    for (int k = 0; k < 400; k++) begin
      rnd_ops();
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
      i_ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
